// File: rtl/mmtiled_tile_job_gen.sv
// Tile-job generator: walks C = A x B in TILE_DIM tiles, emitting one descriptor per (ti,tj,tk).
// Optional feature macro: MMTILED_JOB_STATS_EN adds accepted-job and stall counters.
module mmtiled_tile_job_gen #(
    parameter int         TILE_DIM   = 8,
    parameter int         DATA_SIZE  = 4,
    parameter int         DIM_W      = 32,
    parameter int         ADDR_W     = 64,
    parameter int         ALIGN_BITS = 7,
    parameter logic [7:0] CMD_ID     = 8'd0,
    localparam int        EXT_W      = $clog2(TILE_DIM) + 1
) (
    input  logic              clock,
    input  logic              rstn,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic              job_valid,
    input  logic              job_ready,
    output logic [DIM_W-1:0]  job_ti,
    output logic [DIM_W-1:0]  job_tj,
    output logic [DIM_W-1:0]  job_tk,
    output logic [ADDR_W-1:0] job_addr_a,
    output logic [ADDR_W-1:0] job_addr_b,
    output logic [ADDR_W-1:0] job_addr_c,
    output logic [EXT_W-1:0]  job_rows,
    output logic [EXT_W-1:0]  job_cols,
    output logic [EXT_W-1:0]  job_depth,
    output logic              job_first_k,
    output logic              job_last_k,
    output logic [7:0]        job_cmd_id,
`ifdef MMTILED_JOB_STATS_EN
    output logic [31:0]       stat_jobs,
    output logic [31:0]       stat_stalls,
`endif
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int                LOG2_TD  = $clog2(TILE_DIM);
    localparam int                LOG2_DS  = $clog2(DATA_SIZE);
    localparam logic [DIM_W-1:0]  TD_DIM   = DIM_W'(TILE_DIM);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(TILE_DIM * DATA_SIZE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ISSUE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic              job_valid_q, job_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [DIM_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
    logic [DIM_W-1:0]  ti_q, ti_d, tj_q, tj_d, tk_q, tk_d;
    logic [DIM_W-1:0]  rem_i_q, rem_i_d, rem_j_q, rem_j_d, rem_k_q, rem_k_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [ADDR_W-1:0] a_row_q, a_row_d, b_col_q, b_col_d, c_row_q, c_row_d;
    logic [EXT_W-1:0]  rows_q, rows_d, cols_q, cols_d, depth_q, depth_d;
    logic              first_k_q, first_k_d, last_k_q, last_k_d;
    logic [7:0]        cmd_id_q, cmd_id_d;

    logic [DIM_W-1:0]  t_s;
    logic [DIM_W-1:0]  t_last_s;
    logic [ADDR_W-1:0] row_step_s;
    logic              misalign_s;
    logic              accept_s;
    logic              last_job_s;
    logic              load_s;
    logic              adv_s;

    // Valid extent of a tile given the elements remaining from its origin.
    function automatic logic [EXT_W-1:0] ext_of(input logic [DIM_W-1:0] rem);
        logic [EXT_W-1:0] ext;
        if (rem >= TD_DIM) begin
            ext = EXT_W'(TILE_DIM);
        end else begin
            ext = rem[EXT_W-1:0];
        end
        return ext;
    endfunction

    // Tile count, row stride in bytes (TILE_DIM rows of N elements), and handshake decode.
    always_comb begin
        t_s        = (n_q >> LOG2_TD) + DIM_W'(|n_q[LOG2_TD-1:0]);
        t_last_s   = t_s - DIM_W'(1);
        row_step_s = ADDR_W'(n_q) << (LOG2_TD + LOG2_DS);
        misalign_s = (|base_a_q[ALIGN_BITS-1:0]) | (|base_b_q[ALIGN_BITS-1:0])
                   | (|base_c_q[ALIGN_BITS-1:0]);
        accept_s   = job_valid_q & job_ready;
        last_job_s = accept_s && (ti_q == t_last_s) && (tj_q == t_last_s) && (tk_q == t_last_s);
        load_s     = (state_q == S_SETUP);
        adv_s      = accept_s && !last_job_s;
    end

    // FSM state register.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (misalign_s) begin
                    state_d = S_ERR;
                end else if (n_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_job_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so the flags come straight from flops.
    always_comb begin
        job_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE) || (state_d == S_ERR);
        if ((state_q == S_IDLE) && start) begin
            error_d = 1'b0;
        end else if (state_d == S_ERR) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Datapath next state: counters advance tk fastest; addresses step by adds only.
    always_comb begin
        n_d       = n_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        base_c_d  = base_c_q;
        ti_d      = ti_q;
        tj_d      = tj_q;
        tk_d      = tk_q;
        rem_i_d   = rem_i_q;
        rem_j_d   = rem_j_q;
        rem_k_d   = rem_k_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        addr_c_d  = addr_c_q;
        a_row_d   = a_row_q;
        b_col_d   = b_col_q;
        c_row_d   = c_row_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        depth_d   = depth_q;
        first_k_d = first_k_q;
        last_k_d  = last_k_q;
        cmd_id_d  = cmd_id_q;

        if ((state_q == S_IDLE) && start) begin
            n_d      = dim_n;
            base_a_d = base_a;
            base_b_d = base_b;
            base_c_d = base_c;
        end else if (load_s) begin
            ti_d     = '0;
            tj_d     = '0;
            tk_d     = '0;
            rem_i_d  = n_q;
            rem_j_d  = n_q;
            rem_k_d  = n_q;
            addr_a_d = base_a_q;
            addr_b_d = base_b_q;
            addr_c_d = base_c_q;
            a_row_d  = base_a_q;
            b_col_d  = base_b_q;
            c_row_d  = base_c_q;
            cmd_id_d = CMD_ID;
        end else if (adv_s) begin
            if (tk_q != t_last_s) begin
                tk_d     = tk_q + DIM_W'(1);
                rem_k_d  = rem_k_q - TD_DIM;
                addr_a_d = addr_a_q + COL_STEP;
                addr_b_d = addr_b_q + row_step_s;
            end else begin
                tk_d    = '0;
                rem_k_d = n_q;
                if (tj_q != t_last_s) begin
                    tj_d     = tj_q + DIM_W'(1);
                    rem_j_d  = rem_j_q - TD_DIM;
                    addr_a_d = a_row_q;
                    b_col_d  = b_col_q + COL_STEP;
                    addr_b_d = b_col_q + COL_STEP;
                    addr_c_d = addr_c_q + COL_STEP;
                end else begin
                    tj_d     = '0;
                    rem_j_d  = n_q;
                    ti_d     = ti_q + DIM_W'(1);
                    rem_i_d  = rem_i_q - TD_DIM;
                    a_row_d  = a_row_q + row_step_s;
                    addr_a_d = a_row_q + row_step_s;
                    b_col_d  = base_b_q;
                    addr_b_d = base_b_q;
                    c_row_d  = c_row_q + row_step_s;
                    addr_c_d = c_row_q + row_step_s;
                end
            end
        end else begin
            n_d = n_q;
        end

        if (load_s || adv_s) begin
            rows_d    = ext_of(rem_i_d);
            cols_d    = ext_of(rem_j_d);
            depth_d   = ext_of(rem_k_d);
            first_k_d = (tk_d == '0);
            last_k_d  = (tk_d == t_last_s);
        end else begin
            first_k_d = first_k_q;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            job_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            n_q         <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_c_q    <= '0;
            ti_q        <= '0;
            tj_q        <= '0;
            tk_q        <= '0;
            rem_i_q     <= '0;
            rem_j_q     <= '0;
            rem_k_q     <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_c_q    <= '0;
            a_row_q     <= '0;
            b_col_q     <= '0;
            c_row_q     <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            depth_q     <= '0;
            first_k_q   <= 1'b0;
            last_k_q    <= 1'b0;
            cmd_id_q    <= 8'd0;
        end else begin
            job_valid_q <= job_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            n_q         <= n_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            base_c_q    <= base_c_d;
            ti_q        <= ti_d;
            tj_q        <= tj_d;
            tk_q        <= tk_d;
            rem_i_q     <= rem_i_d;
            rem_j_q     <= rem_j_d;
            rem_k_q     <= rem_k_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_c_q    <= addr_c_d;
            a_row_q     <= a_row_d;
            b_col_q     <= b_col_d;
            c_row_q     <= c_row_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            depth_q     <= depth_d;
            first_k_q   <= first_k_d;
            last_k_q    <= last_k_d;
            cmd_id_q    <= cmd_id_d;
        end
    end

`ifdef MMTILED_JOB_STATS_EN
    logic [31:0] stat_jobs_q, stat_jobs_d, stat_stalls_q, stat_stalls_d;

    // Saturating job/stall counters, cleared by an accepted start.
    always_comb begin
        stat_jobs_d   = stat_jobs_q;
        stat_stalls_d = stat_stalls_q;
        if ((state_q == S_IDLE) && start) begin
            stat_jobs_d   = 32'd0;
            stat_stalls_d = 32'd0;
        end else begin
            if (accept_s && (stat_jobs_q != 32'hFFFF_FFFF)) begin
                stat_jobs_d = stat_jobs_q + 32'd1;
            end else begin
                stat_jobs_d = stat_jobs_q;
            end
            if (job_valid_q && !job_ready && (stat_stalls_q != 32'hFFFF_FFFF)) begin
                stat_stalls_d = stat_stalls_q + 32'd1;
            end else begin
                stat_stalls_d = stat_stalls_q;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            stat_jobs_q   <= 32'd0;
            stat_stalls_q <= 32'd0;
        end else begin
            stat_jobs_q   <= stat_jobs_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_jobs   = stat_jobs_q;
    assign stat_stalls = stat_stalls_q;
`endif

    assign job_valid   = job_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign job_ti      = ti_q;
    assign job_tj      = tj_q;
    assign job_tk      = tk_q;
    assign job_addr_a  = addr_a_q;
    assign job_addr_b  = addr_b_q;
    assign job_addr_c  = addr_c_q;
    assign job_rows    = rows_q;
    assign job_cols    = cols_q;
    assign job_depth   = depth_q;
    assign job_first_k = first_k_q;
    assign job_last_k  = last_k_q;
    assign job_cmd_id  = cmd_id_q;

endmodule

// File: tb/tb_mmtiled_tile_job_gen.sv
// Randomized self-checking bench for mmtiled_tile_job_gen against a nested-loop job-list model.
module tb_mmtiled_tile_job_gen;

    localparam int TD = 8;
    localparam int DS = 4;

    logic        clock = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] dim_n;
    logic [63:0] base_a, base_b, base_c;
    logic        job_ready;
    logic        job_valid;
    logic [31:0] job_ti, job_tj, job_tk;
    logic [63:0] job_addr_a, job_addr_b, job_addr_c;
    logic [3:0]  job_rows, job_cols, job_depth;
    logic        job_first_k, job_last_k;
    logic [7:0]  job_cmd_id;
    logic        busy, done, error;
`ifdef MMTILED_JOB_STATS_EN
    logic [31:0] stat_jobs, stat_stalls;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint unsigned ti, tj, tk;
        logic [63:0]     a, b, c;
        longint unsigned rows, cols, depth;
        bit              fk, lk;
    } job_t;

    mmtiled_tile_job_gen dut (
        .clock(clock), .rstn(rstn), .start(start), .dim_n(dim_n),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_ti(job_ti), .job_tj(job_tj), .job_tk(job_tk),
        .job_addr_a(job_addr_a), .job_addr_b(job_addr_b), .job_addr_c(job_addr_c),
        .job_rows(job_rows), .job_cols(job_cols), .job_depth(job_depth),
        .job_first_k(job_first_k), .job_last_k(job_last_k), .job_cmd_id(job_cmd_id),
`ifdef MMTILED_JOB_STATS_EN
        .stat_jobs(stat_jobs), .stat_stalls(stat_stalls),
`endif
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(job_valid), 64'd0);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_done"},  64'(done),      64'd0);
        chk({tag, "_error"}, 64'(error),     64'd0);
        chk({tag, "_ti"},    64'(job_ti),    64'd0);
        chk({tag, "_addra"}, job_addr_a,     64'd0);
        chk({tag, "_rows"},  64'(job_rows),  64'd0);
        chk({tag, "_firstk"}, 64'(job_first_k), 64'd0);
    endtask

    // mode: 0 = ready tied high, 1 = ready 1-of-3 cycles, 2 = ready 50%.
    // stop_after > 0 asserts rstn after that many accepts.
    task automatic run_job(input longint unsigned n, input logic [63:0] ba, input logic [63:0] bb,
                           input logic [63:0] bc, input int mode, input int stop_after);
        job_t            q[$];
        job_t            jb;
        longint unsigned t;
        bit              misal;
        bit              r;
        int              accepts = 0;
        int              stalls  = 0;
        int              cycles  = 0;

        t = (n + TD - 1) / TD;
        for (longint unsigned i = 0; i < t; i++) begin
            for (longint unsigned j = 0; j < t; j++) begin
                for (longint unsigned k = 0; k < t; k++) begin
                    jb.ti = i; jb.tj = j; jb.tk = k;
                    jb.a = ba + (i * TD * n + k * TD) * DS;
                    jb.b = bb + (k * TD * n + j * TD) * DS;
                    jb.c = bc + (i * TD * n + j * TD) * DS;
                    jb.rows  = (n - i * TD < TD) ? n - i * TD : TD;
                    jb.cols  = (n - j * TD < TD) ? n - j * TD : TD;
                    jb.depth = (n - k * TD < TD) ? n - k * TD : TD;
                    jb.fk = (k == 0);
                    jb.lk = (k == t - 1);
                    q.push_back(jb);
                end
            end
        end
        misal = ((ba % 128) != 0) || ((bb % 128) != 0) || ((bc % 128) != 0);

        @(negedge clock);
        dim_n = 32'(n); base_a = ba; base_b = bb; base_c = bc; start = 1'b1; job_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        chk("setup_valid", 64'(job_valid), 64'd0);
        chk("setup_busy",  64'(busy),      64'd1);
        chk("setup_error", 64'(error),     64'd0);
        chk("setup_done",  64'(done),      64'd0);
        @(negedge clock);

        if (misal || n == 0) begin
            chk("early_done",  64'(done),      64'd1);
            chk("early_valid", 64'(job_valid), 64'd0);
            chk("early_error", 64'(error),     64'(misal));
            @(negedge clock);
            chk("early_done_off", 64'(done),      64'd0);
            chk("early_idle",     64'(busy),      64'd0);
            chk("early_valid2",   64'(job_valid), 64'd0);
            chk("early_sticky",   64'(error),     64'(misal));
            return;
        end

        while (q.size() > 0 && cycles < 5000) begin
            chk("valid",  64'(job_valid),   64'd1);
            chk("done_lo", 64'(done),       64'd0);
            chk("ti",     64'(job_ti),      q[0].ti);
            chk("tj",     64'(job_tj),      q[0].tj);
            chk("tk",     64'(job_tk),      q[0].tk);
            chk("addr_a", job_addr_a,       q[0].a);
            chk("addr_b", job_addr_b,       q[0].b);
            chk("addr_c", job_addr_c,       q[0].c);
            chk("rows",   64'(job_rows),    q[0].rows);
            chk("cols",   64'(job_cols),    q[0].cols);
            chk("depth",  64'(job_depth),   q[0].depth);
            chk("first_k", 64'(job_first_k), 64'(q[0].fk));
            chk("last_k", 64'(job_last_k),  64'(q[0].lk));
            chk("cmd_id", 64'(job_cmd_id),  64'd0);
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = ($urandom_range(0, 2) == 0);
            else                r = ($urandom_range(0, 1) == 0);
            job_ready = r;
            start     = ($urandom_range(0, 7) == 0);
            dim_n     = $urandom;
            if (r) begin
                void'(q.pop_front());
                accepts++;
            end else begin
                stalls++;
            end
            @(negedge clock);
            cycles++;
            if (stop_after > 0 && accepts == stop_after) begin
                start = 1'b0; job_ready = 1'b0;
                rstn = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                @(negedge clock);
                chk_all_zero("rst_hold");
                rstn = 1'b1;
                return;
            end
        end
        chk("jobs_left", 64'(q.size()), 64'd0);
        start = 1'b0; job_ready = 1'b0;
        chk("done_pulse", 64'(done),      64'd1);
        chk("done_valid", 64'(job_valid), 64'd0);
        chk("done_busy",  64'(busy),      64'd1);
`ifdef MMTILED_JOB_STATS_EN
        chk("stat_jobs",   64'(stat_jobs),   64'(accepts));
        chk("stat_stalls", 64'(stat_stalls), 64'(stalls));
`endif
        @(negedge clock);
        chk("done_off",  64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb, rc;
        rstn = 1'b0; start = 1'b0; job_ready = 1'b0;
        dim_n = 32'd0; base_a = 64'd0; base_b = 64'd0; base_c = 64'd0;
        #12;
        chk_all_zero("reset");
        @(negedge clock);
        rstn = 1'b1;

        run_job(16, 64'h1000, 64'h2000, 64'h3000, 0, -1);
        run_job(12, 64'h1000, 64'h2000, 64'h3000, 0, -1);
        run_job(16, 64'h1000, 64'h2040, 64'h3000, 0, -1);
        run_job(16, 64'h1000, 64'h2000, 64'h3000, 0, -1);
        run_job(16, 64'h1000, 64'h2000, 64'h3000, 1, -1);
        run_job(0,  64'h1000, 64'h2000, 64'h3000, 0, -1);
        run_job(16, 64'h1000, 64'h2000, 64'h3000, 0, 3);
        run_job(16, 64'h1000, 64'h2000, 64'h3000, 0, -1);
        run_job(1,  64'h0080, 64'h0100, 64'h0180, 2, -1);
        run_job(9,  64'hFFFF_FFFF_FFFF_FF80, 64'h0, 64'h4000_0000, 2, -1);
        run_job(8,  64'h0, 64'h0, 64'h0, 1, -1);

        for (int it = 0; it < 12; it++) begin
            ra = {$urandom, $urandom} & ~64'h7F;
            rb = {$urandom, $urandom} & ~64'h7F;
            rc = {$urandom, $urandom} & ~64'h7F;
            if ($urandom_range(0, 5) == 0) rc = rc | 64'h8;
            run_job(longint'($urandom_range(0, 40)), ra, rb, rc, 2, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
